// File: rtl/pulse_gen_out_pkg.sv
// Shared definitions for the output pulse generator: state encoding and clock timing.
package pulse_gen_out_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_HIGH = 2'b01;
    localparam logic [1:0] ST_LOW  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        HIGH = ST_HIGH,
        LOW  = ST_LOW
    } state_e;

    // 125 MHz system clock.
    localparam int CLK_PERIOD_NS = 8;

    function automatic int ns_to_cycles(input int ns);
        return (ns + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
    endfunction

endpackage

// File: rtl/pulse_gen_out_pend.sv
// pend_sat_counter: up/down counter that saturates at all-ones and at zero;
// ovf flags an increment that was dropped because the counter was full.
module pend_sat_counter
    import pulse_gen_out_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full,
    output logic         ovf
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign full  = (count_q == {W{1'b1}});
    assign ovf   = inc && !dec && full;
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (inc && !dec && !full) begin
            count_d = count_q + 1'b1;
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pulse_gen_out.sv
// Output pulse generator: trig -> pulse of hi_len cycles high then lo_len cycles low.
// Define PULSE_GEN_QUEUE_EN to queue requests that arrive while a pulse is running.
module pulse_gen_out
    import pulse_gen_out_pkg::*;
#(
    parameter int W      = 8,
    parameter int PEND_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trig,
    input  logic [W-1:0]      hi_len,
    input  logic [W-1:0]      lo_len,
    input  logic              ovf_clr,
    output logic              out,
    output logic              busy,
    output logic              done_tick,
    output logic [PEND_W-1:0] pend,
    output logic              ovf
);

    localparam logic [W-1:0] ONE = W'(1);

    state_e       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic         out_q, out_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         ovf_q, ovf_d;

    logic [W-1:0] h_load;
    logic [W-1:0] l_load;
    logic         launch;
    logic         launch_req;
    logic         ovf_set;

    assign h_load     = (hi_len == '0) ? ONE : hi_len;
    assign l_load     = (lo_len == '0) ? ONE : lo_len;
    assign launch_req = trig || (pend != '0);

`ifdef PULSE_GEN_QUEUE_EN
    // A launch always takes a same-cycle trig first, so pend only drains when trig is low.
    logic pend_inc;
    logic pend_dec;
    logic pend_full;

    assign pend_inc = trig && !launch;
    assign pend_dec = launch && !trig;

    pend_sat_counter #(
        .W (PEND_W)
    ) u_pend (
        .clk   (clk),
        .rst   (reset),
        .inc   (pend_inc),
        .dec   (pend_dec),
        .count (pend),
        .full  (pend_full),
        .ovf   (ovf_set)
    );
`else
    assign pend    = '0;
    assign ovf_set = trig && !launch;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        launch  = 1'b0;
        case (state_q)
            IDLE: begin
                if (launch_req) begin
                    launch  = 1'b1;
                    state_d = HIGH;
                    cnt_d   = h_load;
                end
            end
            HIGH: begin
                if (cnt_q <= ONE) begin
                    state_d = LOW;
                    cnt_d   = l_load;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            LOW: begin
                if (cnt_q <= ONE) begin
                    if (launch_req) begin
                        launch  = 1'b1;
                        state_d = HIGH;
                        cnt_d   = h_load;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        out_d  = (state_d == HIGH);
        busy_d = (state_d != IDLE);
    end

    // A fresh overflow beats a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out       = out_q;
    assign busy      = busy_q;
    assign done_tick = done_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pulse_gen_out.sv
// Directed bench for pulse_gen_out: expected pulses are queued when triggers are driven
// and matched against rising/falling edges of out.
module tb_pulse_gen_out;

    localparam int W      = 8;
    localparam int PEND_W = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              trig = 1'b0;
    logic              ovf_clr = 1'b0;
    logic [W-1:0]      hi_len = '0;
    logic [W-1:0]      lo_len = '0;
    logic              out;
    logic              busy;
    logic              done_tick;
    logic [PEND_W-1:0] pend;
    logic              ovf;

    int   total = 0;
    int   bad = 0;
    int   edge_cnt = 0;
    bit   mon_en = 1'b0;
    logic prev_out = 1'b0;
    int   rise_at = 0;

    typedef struct {
        int rise;
        int hi;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    pulse_gen_out #(
        .W      (W),
        .PEND_W (PEND_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .trig      (trig),
        .hi_len    (hi_len),
        .lo_len    (lo_len),
        .ovf_clr   (ovf_clr),
        .out       (out),
        .busy      (busy),
        .done_tick (done_tick),
        .pend      (pend),
        .ovf       (ovf)
    );

    always #4 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endfunction

    function automatic void push(input int r, input int h);
        exp_t x;
        x.rise = r;
        x.hi   = h;
        exp_q.push_back(x);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!mon_en || reset) begin
            prev_out = out;
        end else begin
            chk("done_on_fall", {31'b0, done_tick}, {31'b0, prev_out && !out});
            if (out && !prev_out) begin
                chk("pulse_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    chk("rise_edge", edge_cnt, cur.rise);
                end
                rise_at = edge_cnt;
            end
            if (!out && prev_out) begin
                chk("high_cycles", edge_cnt - rise_at, cur.hi);
            end
            $display("edge=%0d out=%0b busy=%0b done=%0b pend=%0d ovf=%0b",
                     edge_cnt, out, busy, done_tick, pend, ovf);
            prev_out = out;
        end
    end

    initial begin
        int e;
        int n;

        repeat (2) step();
        chk("rst_out", {31'b0, out}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done_tick}, 0);
        chk("rst_pend", 32'(pend), 0);
        chk("rst_ovf", {31'b0, ovf}, 0);
        reset = 1'b0;
        mon_en = 1'b1;
        step();

        // Single pulse, H=5 L=3.
        hi_len = 8'd5;
        lo_len = 8'd3;
        e = edge_cnt;
        trig = 1'b1;
        push(e + 1, 5);
        step();
        trig = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            n += int'(busy);
            step();
        end
        chk("a_busy_cycles", n, 8);
        chk("a_pend", 32'(pend), 0);
        chk("a_ovf", {31'b0, ovf}, 0);
        chk("a_all_pulses", exp_q.size(), 0);

        // Zero lengths behave as one cycle each.
        hi_len = 8'd0;
        lo_len = 8'd0;
        e = edge_cnt;
        trig = 1'b1;
        push(e + 1, 1);
        step();
        trig = 1'b0;
        chk("b_out_high", {31'b0, out}, 1);
        step();
        chk("b_low_busy", {31'b0, busy}, 1);
        chk("b_low_out", {31'b0, out}, 0);
        chk("b_low_done", {31'b0, done_tick}, 1);
        step();
        chk("b_idle_busy", {31'b0, busy}, 0);
        step();
        chk("b_all_pulses", exp_q.size(), 0);

`ifdef PULSE_GEN_QUEUE_EN
        // Three back-to-back requests, H=4 L=2.
        hi_len = 8'd4;
        lo_len = 8'd2;
        e = edge_cnt;
        trig = 1'b1;
        push(e + 1, 4);
        push(e + 7, 4);
        push(e + 13, 4);
        repeat (3) step();
        trig = 1'b0;
        chk("c_pend_peak", 32'(pend), 2);
        repeat (16) step();
        chk("c_pend_end", 32'(pend), 0);
        chk("c_ovf", {31'b0, ovf}, 0);
        chk("c_busy_end", {31'b0, busy}, 0);
        chk("c_all_pulses", exp_q.size(), 0);

        // Saturation: 11 requests during a long pulse, queue depth 7.
        hi_len = 8'd20;
        lo_len = 8'd2;
        e = edge_cnt;
        trig = 1'b1;
        for (int k = 0; k < 8; k++) push(e + 1 + 22 * k, 20);
        repeat (10) step();
        ovf_clr = 1'b1;
        step();
        trig = 1'b0;
        chk("d_pend_sat", 32'(pend), 7);
        chk("d_ovf_set_wins", {31'b0, ovf}, 1);
        step();
        ovf_clr = 1'b0;
        chk("d_ovf_cleared", {31'b0, ovf}, 0);
        chk("d_pend_held", 32'(pend), 7);
        repeat (8 * 22 + 4) step();
        chk("d_pend_end", 32'(pend), 0);
        chk("d_busy_end", {31'b0, busy}, 0);
        chk("d_all_pulses", exp_q.size(), 0);
`else
        // No queue: requests while busy are dropped, except at the end of LOW.
        hi_len = 8'd4;
        lo_len = 8'd4;
        e = edge_cnt;
        trig = 1'b1;
        push(e + 1, 4);
        step();
        step();
        chk("c_drop_ovf", {31'b0, ovf}, 1);
        chk("c_pend_zero", 32'(pend), 0);
        ovf_clr = 1'b1;
        step();
        chk("c_ovf_set_wins", {31'b0, ovf}, 1);
        trig = 1'b0;
        step();
        chk("c_ovf_cleared", {31'b0, ovf}, 0);
        ovf_clr = 1'b0;
        repeat (4) step();
        trig = 1'b1;
        push(e + 9, 4);
        step();
        trig = 1'b0;
        chk("c_lowend_launch", {31'b0, out}, 1);
        chk("c_lowend_no_ovf", {31'b0, ovf}, 0);
        repeat (9) step();
        chk("c_busy_end", {31'b0, busy}, 0);
        chk("c_all_pulses", exp_q.size(), 0);
`endif

        // Reset in the middle of a pulse.
        hi_len = 8'd10;
        lo_len = 8'd3;
        mon_en = 1'b0;
        trig = 1'b1;
        step();
        chk("r_out_high", {31'b0, out}, 1);
        step();
        trig = 1'b0;
        step();
        #1;
        reset = 1'b1;
        #1;
        chk("r_async_out", {31'b0, out}, 0);
        chk("r_async_busy", {31'b0, busy}, 0);
        chk("r_async_pend", 32'(pend), 0);
        step();
        chk("r_no_done", {31'b0, done_tick}, 0);
        chk("r_ovf", {31'b0, ovf}, 0);
        reset = 1'b0;
        step();
        mon_en = 1'b1;
        e = edge_cnt;
        trig = 1'b1;
        push(e + 1, 10);
        step();
        trig = 1'b0;
        repeat (16) step();
        chk("r_busy_end", {31'b0, busy}, 0);
        chk("r_all_pulses", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
